// File: rtl/q_sync_register_pkg.sv
// rtl/q_sync_register_pkg.sv - shared types for the Q-module word sampler
package q_pkg;

    // Handshake/settling FSM states of the word sampler
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2,
        ACK    = 2'd3
    } q_state_t;

    // Default geometry of the sampler
    localparam int Q_DEF_WIDTH         = 8;
    localparam int Q_DEF_SYNC_STAGES   = 2;
    localparam int Q_DEF_STABLE_CYCLES = 3;
    localparam int Q_DEF_MAX_WAIT      = 16;
    localparam int Q_DEF_DEPTH         = 4;

endpackage

// File: rtl/q_sync_register_if.sv
// rtl/q_sync_register_if.sv - sample/ack request side and valid/ready word port
interface q_sync_register_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data;
    logic             sample;
    logic             ack;
    logic [WIDTH-1:0] out;
    logic             out_timeout;
    logic             out_valid;
    logic             out_ready;

    // Environment side: drives the asynchronous request and consumes words
    modport master (
        output data, sample, out_ready,
        input  ack, out, out_timeout, out_valid
    );

    // Sampler side
    modport slave (
        input  data, sample, out_ready,
        output ack, out, out_timeout, out_valid
    );
endinterface

// File: rtl/q_sync_register_fifo.sv
// rtl/q_sync_register_fifo.sv - show-ahead FIFO buffering resolved words
module q_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_valid,
    output logic             o_full
);
    localparam int                PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]    ONE_COUNT  = (PTR_W+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic [PTR_W-1:0] w_next_rd;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL_COUNT);
    assign w_pop     = i_pop && !w_empty;
    // A pop frees the slot on the same edge, so a full FIFO can still accept
    assign w_push    = i_push && (!w_full || w_pop);
    assign w_next_rd = r_rd_ptr + PTR_W'(1);

    assign o_head  = r_head;
    assign o_valid = !w_empty;
    assign o_full  = w_full;

    // Storage array; content is only meaningful between the pointers
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_next_rd;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + ONE_COUNT;
                2'b01:   r_count <= r_count - ONE_COUNT;
                default: r_count <= r_count;
            endcase
        end
    end

    // Registered head word: keeps its last value once the FIFO drains
    always_ff @(posedge clock) begin
        if (reset) begin
            r_head <= '0;
        end else if (w_empty) begin
            if (w_push) begin
                r_head <= i_push_data;
            end
        end else if (w_pop) begin
            if (r_count == ONE_COUNT) begin
                if (w_push) begin
                    r_head <= i_push_data;
                end
            end else begin
                r_head <= r_mem[w_next_rd];
            end
        end
    end

endmodule

// File: rtl/q_sync_register.sv
// rtl/q_sync_register.sv - multi-bit Q-flop sampler with settle/timeout resolve and output FIFO
module q_sync_register
    import q_pkg::*;
#(
    parameter int WIDTH         = Q_DEF_WIDTH,
    parameter int SYNC_STAGES   = Q_DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = Q_DEF_STABLE_CYCLES,
    parameter int MAX_WAIT      = Q_DEF_MAX_WAIT,
    parameter int DEPTH         = Q_DEF_DEPTH
) (
    input  logic                clock,
    input  logic                reset,
    q_sync_register_if.slave    bus
);
    localparam int SC_W = $clog2(STABLE_CYCLES + 1);
    localparam int WC_W = $clog2(MAX_WAIT + 1);

    typedef struct packed {
        logic             timeout;
        logic [WIDTH-1:0] word;
    } q_entry_t;

    logic [WIDTH-1:0]       r_data_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] r_sample_sync;
    logic [WIDTH-1:0]       w_data_s;
    logic                   w_sample_s;

    q_state_t               r_state;
    q_state_t               w_state_next;

    logic [WIDTH-1:0]       r_data_prev;
    logic [SC_W-1:0]        r_stable_cnt;
    logic [WC_W-1:0]        r_wait_cnt;
    logic [WIDTH-1:0]       r_hold_word;
    logic                   r_hold_tflag;

    logic                   w_match;
    logic                   w_stable_hit;
    logic                   w_timeout_hit;
    logic                   w_resolve;
    logic                   w_tflag;

    logic                   w_push;
    q_entry_t               w_push_entry;
    logic                   w_pop;
    logic                   w_can_push;
    logic                   w_ack;
    q_entry_t               w_head;
    logic                   w_fifo_valid;
    logic                   w_fifo_full;

    // Synchroniser chains for the asynchronous word and request
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_data_sync[i] <= '0;
            end
            r_sample_sync <= '0;
        end else begin
            r_data_sync[0] <= bus.data;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_data_sync[i] <= r_data_sync[i-1];
            end
            r_sample_sync <= {r_sample_sync[SYNC_STAGES-2:0], bus.sample};
        end
    end

    assign w_data_s   = r_data_sync[SYNC_STAGES-1];
    assign w_sample_s = r_sample_sync[SYNC_STAGES-1];

    // Resolve decision; a stable resolve takes precedence over the timeout
    assign w_match       = (w_data_s == r_data_prev);
    assign w_stable_hit  = w_match && (r_stable_cnt == SC_W'(STABLE_CYCLES - 1));
    assign w_timeout_hit = (r_wait_cnt == WC_W'(MAX_WAIT - 1));
    assign w_resolve     = w_stable_hit || w_timeout_hit;
    assign w_tflag       = !w_stable_hit;

    assign w_pop      = w_fifo_valid && bus.out_ready;
    assign w_can_push = !w_fifo_full || w_pop;

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic; a dropped request only aborts while still settling
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_sample_s) begin
                    w_state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (!w_sample_s) begin
                    w_state_next = IDLE;
                end else if (w_resolve) begin
                    w_state_next = w_can_push ? ACK : HOLD;
                end
            end
            HOLD: begin
                if (w_can_push) begin
                    w_state_next = ACK;
                end
            end
            ACK: begin
                if (!w_sample_s) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // FSM outputs: FIFO push request and the ack level
    always_comb begin
        w_push       = 1'b0;
        w_push_entry = '{timeout: r_hold_tflag, word: r_hold_word};
        w_ack        = 1'b0;
        case (r_state)
            SETTLE: begin
                if (w_sample_s && w_resolve && w_can_push) begin
                    w_push       = 1'b1;
                    w_push_entry = '{timeout: w_tflag, word: w_data_s};
                end
            end
            HOLD: begin
                w_push = w_can_push;
            end
            ACK: begin
                w_ack = 1'b1;
            end
            default: begin
                w_push = 1'b0;
            end
        endcase
    end

    // Settling datapath: previous sample, saturating counters, parked word
    always_ff @(posedge clock) begin
        if (reset) begin
            r_data_prev  <= '0;
            r_stable_cnt <= '0;
            r_wait_cnt   <= '0;
            r_hold_word  <= '0;
            r_hold_tflag <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_sample_s) begin
                        r_data_prev  <= w_data_s;
                        r_stable_cnt <= '0;
                        r_wait_cnt   <= '0;
                    end
                end
                SETTLE: begin
                    r_data_prev <= w_data_s;
                    if (!w_match) begin
                        r_stable_cnt <= '0;
                    end else if (r_stable_cnt != SC_W'(STABLE_CYCLES)) begin
                        r_stable_cnt <= r_stable_cnt + SC_W'(1);
                    end
                    if (r_wait_cnt != WC_W'(MAX_WAIT)) begin
                        r_wait_cnt <= r_wait_cnt + WC_W'(1);
                    end
                    if (w_sample_s && w_resolve) begin
                        r_hold_word  <= w_data_s;
                        r_hold_tflag <= w_tflag;
                    end
                end
                default: begin
                    r_data_prev <= r_data_prev;
                end
            endcase
        end
    end

    q_fifo #(
        .WIDTH (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_valid     (w_fifo_valid),
        .o_full      (w_fifo_full)
    );

    assign bus.ack         = w_ack;
    assign bus.out         = w_head.word;
    assign bus.out_timeout = w_head.timeout;
    assign bus.out_valid   = w_fifo_valid;

endmodule

// File: tb/tb_q_sync_register.sv
// tb/tb_q_sync_register.sv - directed self-checking bench for q_sync_register
module tb_q_sync_register;
    import q_pkg::*;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    q_sync_register_if #(.WIDTH(8)) bus ();

    q_sync_register #(
        .WIDTH         (8),
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (3),
        .MAX_WAIT      (16),
        .DEPTH         (4)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_ack(input logic lvl, input string tag);
        int n;
        n = 0;
        while (bus.ack !== lvl && n < 40) begin
            tick();
            n++;
        end
        check(tag, 32'(bus.ack), 32'(lvl));
    endtask

    task automatic handshake(input logic [7:0] v, input string tag);
        bus.data = v;
        repeat (3) tick();
        bus.sample = 1'b1;
        wait_ack(1'b1, tag);
        bus.sample = 1'b0;
        wait_ack(1'b0, tag);
    endtask

    task automatic pop_expect(input logic [7:0] v, input logic tflag, input string tag);
        check(tag, {22'd0, bus.out_valid, bus.out_timeout, bus.out}, {22'd0, 1'b1, tflag, v});
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic ack_seen;
        n_pass        = 0;
        n_total       = 0;
        rst           = 1'b1;
        bus.data      = 8'h00;
        bus.sample    = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_ack", 32'(bus.ack), 32'd0);
        check("reset_valid", 32'(bus.out_valid), 32'd0);
        check("reset_out", {23'd0, bus.out_timeout, bus.out}, 32'd0);
        check("reset_state", 32'(dut.r_state), 32'(IDLE));

        // 1: constant word resolves at E5
        bus.data = 8'hA5;
        repeat (3) tick();
        bus.sample = 1'b1;
        repeat (5) tick();
        check("t1_e4_ack", 32'(bus.ack), 32'd0);
        check("t1_e4_valid", 32'(bus.out_valid), 32'd0);
        tick();
        check("t1_e5_ack", 32'(bus.ack), 32'd1);
        check("t1_e5_head", {22'd0, bus.out_valid, bus.out_timeout, bus.out}, {22'd0, 1'b1, 1'b0, 8'hA5});
        bus.sample = 1'b0;
        tick();
        check("t1_drop_f0", 32'(bus.ack), 32'd1);
        tick();
        check("t1_drop_f1", 32'(bus.ack), 32'd1);
        tick();
        check("t1_drop_f2", 32'(bus.ack), 32'd0);
        pop_expect(8'hA5, 1'b0, "t1_pop");
        check("t1_empty", 32'(bus.out_valid), 32'd0);
        check("t1_keep_last", {23'd0, bus.out_timeout, bus.out}, {23'd0, 1'b0, 8'hA5});

        // 2: toggling word forces a timeout resolve on the 16th SETTLE edge
        bus.data   = 8'hA5;
        bus.sample = 1'b1;
        for (int k = 0; k < 18; k++) begin
            tick();
            bus.data = ~bus.data;
        end
        check("t2_e17_ack", 32'(bus.ack), 32'd0);
        check("t2_e17_valid", 32'(bus.out_valid), 32'd0);
        tick();
        check("t2_e18_ack", 32'(bus.ack), 32'd1);
        check("t2_e18_head", {22'd0, bus.out_valid, bus.out_timeout, bus.out}, {22'd0, 1'b1, 1'b1, 8'hA5});
        bus.sample = 1'b0;
        wait_ack(1'b0, "t2_ack_fall");
        pop_expect(8'hA5, 1'b1, "t2_pop");
        check("t2_empty", 32'(bus.out_valid), 32'd0);

        // 3: full FIFO parks the fifth word in HOLD until a pop
        handshake(8'h01, "t3_hs1");
        handshake(8'h02, "t3_hs2");
        handshake(8'h03, "t3_hs3");
        handshake(8'h04, "t3_hs4");
        bus.data = 8'h05;
        repeat (3) tick();
        bus.sample = 1'b1;
        repeat (10) tick();
        check("t3_hold_ack", 32'(bus.ack), 32'd0);
        check("t3_hold_state", 32'(dut.r_state), 32'(HOLD));
        check("t3_head01", 32'(bus.out), 32'h01);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("t3_pop_ack", 32'(bus.ack), 32'd1);
        check("t3_pop_head", {23'd0, bus.out_valid, bus.out}, {23'd0, 1'b1, 8'h02});
        bus.sample = 1'b0;
        wait_ack(1'b0, "t3_ack_fall");
        pop_expect(8'h02, 1'b0, "t3_drain02");
        pop_expect(8'h03, 1'b0, "t3_drain03");
        pop_expect(8'h04, 1'b0, "t3_drain04");
        pop_expect(8'h05, 1'b0, "t3_drain05");
        check("t3_empty", 32'(bus.out_valid), 32'd0);

        // 4: request withdrawn while settling
        bus.data = 8'h33;
        repeat (3) tick();
        bus.sample = 1'b1;
        tick();
        tick();
        bus.sample = 1'b0;
        tick();
        tick();
        check("t4_settle", 32'(dut.r_state), 32'(SETTLE));
        tick();
        check("t4_abort_idle", 32'(dut.r_state), 32'(IDLE));
        ack_seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.ack === 1'b1) ack_seen = 1'b1;
        end
        check("t4_no_ack", 32'(ack_seen), 32'd0);
        check("t4_no_push", 32'(bus.out_valid), 32'd0);

        // 5: reset while settling with two buffered words
        handshake(8'h11, "t5_hs1");
        handshake(8'h22, "t5_hs2");
        bus.data = 8'h33;
        repeat (3) tick();
        bus.sample = 1'b1;
        repeat (3) tick();
        check("t5_pre_state", 32'(dut.r_state), 32'(SETTLE));
        check("t5_pre_head", {23'd0, bus.out_valid, bus.out}, {23'd0, 1'b1, 8'h11});
        rst        = 1'b1;
        bus.sample = 1'b0;
        tick();
        rst = 1'b0;
        check("t5_valid", 32'(bus.out_valid), 32'd0);
        check("t5_ack", 32'(bus.ack), 32'd0);
        check("t5_state", 32'(dut.r_state), 32'(IDLE));
        check("t5_out", {23'd0, bus.out_timeout, bus.out}, 32'd0);
        repeat (3) tick();

        // 6: full FIFO with pop and resolve on the same edge
        handshake(8'h61, "t6_hs1");
        handshake(8'h62, "t6_hs2");
        handshake(8'h63, "t6_hs3");
        handshake(8'h64, "t6_hs4");
        bus.data = 8'h65;
        repeat (3) tick();
        bus.sample = 1'b1;
        repeat (5) tick();
        check("t6_e4_ack", 32'(bus.ack), 32'd0);
        check("t6_e4_state", 32'(dut.r_state), 32'(SETTLE));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("t6_e5_ack", 32'(bus.ack), 32'd1);
        check("t6_e5_state", 32'(dut.r_state), 32'(ACK));
        check("t6_e5_head", {23'd0, bus.out_valid, bus.out}, {23'd0, 1'b1, 8'h62});
        bus.sample = 1'b0;
        wait_ack(1'b0, "t6_ack_fall");
        pop_expect(8'h62, 1'b0, "t6_drain62");
        pop_expect(8'h63, 1'b0, "t6_drain63");
        pop_expect(8'h64, 1'b0, "t6_drain64");
        pop_expect(8'h65, 1'b0, "t6_drain65");
        check("t6_empty", 32'(bus.out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
